// File: rtl/vga_timing_pkg.sv
`default_nettype none
// vga_timing_pkg: default VGA timing constants and lock-controller state encoding.
// Rev 1.0
package vga_timing_pkg;

    localparam int unsigned DEF_THRESHOLD_HSYNC = 1024;
    localparam int unsigned DEF_THRESHOLD_VSYNC = 768;
    localparam int unsigned DEF_WHOLE_LINE      = 1368;
    localparam int unsigned DEF_WHOLE_FRAME     = 806;
    localparam int unsigned DEF_COUNTER_SIZE    = 11;
    localparam int unsigned DEF_LOCK_LINES      = 4;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } sync_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_edge_detect.sv
`default_nettype none
// vga_edge_detect: one register stage on a sync input with rise/fall strobes.
// Rev 1.0
module vga_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic sync_q,
    output logic rise,
    output logic fall
);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= sync_in;
        end
    end

    assign rise = sync_in & ~sync_q;
    assign fall = ~sync_in & sync_q;

endmodule
`default_nettype wire

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// vga_sync_decoder: recovers pixel coordinates, line/frame strobes and lock status from VGA syncs.
// Rev 1.0
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int unsigned THRESHOLD_HSYNC = DEF_THRESHOLD_HSYNC,
    parameter int unsigned THRESHOLD_VSYNC = DEF_THRESHOLD_VSYNC,
    parameter int unsigned WHOLE_LINE      = DEF_WHOLE_LINE,
    parameter int unsigned WHOLE_FRAME     = DEF_WHOLE_FRAME,
    parameter int unsigned COUNTER_SIZE    = DEF_COUNTER_SIZE,
    parameter int unsigned LOCK_LINES      = DEF_LOCK_LINES
) (
    input  logic                    control_clock,
    input  logic                    control_reset,
    input  logic                    h_sync,
    input  logic                    v_sync,
    output logic [COUNTER_SIZE-1:0] pixel_x,
    output logic [COUNTER_SIZE-1:0] pixel_y,
    output logic                    display_en,
    output logic                    line_start,
    output logic                    frame_start,
    output logic                    locked,
    output logic                    timing_err
);

    localparam int unsigned CW = $clog2(LOCK_LINES + 1);
    localparam logic [COUNTER_SIZE-1:0] CNT_MAX    = '1;
    localparam logic [COUNTER_SIZE-1:0] CNT_PRESAT = CNT_MAX - 1'b1;
    localparam logic [COUNTER_SIZE-1:0] LINE_LAST  = COUNTER_SIZE'(WHOLE_LINE - 1);
    localparam logic [COUNTER_SIZE-1:0] H_WIDTH    = COUNTER_SIZE'(THRESHOLD_HSYNC);
    localparam logic [COUNTER_SIZE-1:0] F_LINES    = COUNTER_SIZE'(WHOLE_FRAME);
    localparam logic [COUNTER_SIZE-1:0] V_WIDTH    = COUNTER_SIZE'(THRESHOLD_VSYNC);
    localparam logic [CW-1:0]           LOCK_CNT   = CW'(LOCK_LINES);

    logic h_q, h_rise, h_fall;
    logic v_q, v_rise, v_fall;
    logic h_armed, v_armed, v_pending, line_good;
    logic line_bad, frame_bad, timeout;
    logic [COUNTER_SIZE-1:0] h_high_len, v_high_len, frame_lines;
    sync_state_t   state, state_next;
    logic [CW-1:0] good_count, count_next;

    vga_edge_detect u_h_edge (
        .clk     (control_clock),
        .rst     (control_reset),
        .sync_in (h_sync),
        .sync_q  (h_q),
        .rise    (h_rise),
        .fall    (h_fall)
    );

    vga_edge_detect u_v_edge (
        .clk     (control_clock),
        .rst     (control_reset),
        .sync_in (v_sync),
        .sync_q  (v_q),
        .rise    (v_rise),
        .fall    (v_fall)
    );

    assign display_en = h_q & v_q;

    // Period is pixel_x+1 at the next rise; pulse widths are latched at the falling edges.
    assign line_bad  = h_rise & h_armed & ((pixel_x != LINE_LAST) | (h_high_len != H_WIDTH));
    assign frame_bad = v_rise & v_armed & ((frame_lines != F_LINES) | (v_high_len != V_WIDTH));
    assign timeout   = ~h_rise & (pixel_x == CNT_PRESAT);

    always_ff @(posedge control_clock) begin
        if (control_reset) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            timing_err  <= 1'b0;
            line_good   <= 1'b0;
            v_pending   <= 1'b0;
            h_armed     <= 1'b0;
            v_armed     <= 1'b0;
            h_high_len  <= '0;
            v_high_len  <= '0;
            frame_lines <= '0;
        end else begin
            line_start  <= h_rise;
            frame_start <= h_rise & (v_rise | v_pending);
            line_good   <= h_rise & h_armed & ~line_bad;
            timing_err  <= line_bad | frame_bad | timeout;

            if (h_rise) begin
                pixel_x <= '0;
            end else if (pixel_x != CNT_MAX) begin
                pixel_x <= pixel_x + 1'b1;
            end

            if (h_rise) begin
                if (v_rise | v_pending) begin
                    pixel_y <= '0;
                end else if (pixel_y != CNT_MAX) begin
                    pixel_y <= pixel_y + 1'b1;
                end
            end

            if (h_rise) begin
                v_pending <= 1'b0;
            end else if (v_rise) begin
                v_pending <= 1'b1;
            end

            if (timeout) begin
                h_armed <= 1'b0;
            end else if (h_rise) begin
                h_armed <= 1'b1;
            end

            if (v_rise) begin
                v_armed <= 1'b1;
            end

            if (h_fall) begin
                h_high_len <= pixel_x + 1'b1;
            end

            if (v_fall) begin
                v_high_len <= frame_lines;
            end

            if (v_rise) begin
                frame_lines <= COUNTER_SIZE'(h_rise);
            end else if (h_rise && (frame_lines != CNT_MAX)) begin
                frame_lines <= frame_lines + 1'b1;
            end
        end
    end

    always_ff @(posedge control_clock) begin
        if (control_reset) begin
            state      <= ST_SEARCH;
            good_count <= '0;
            locked     <= 1'b0;
        end else begin
            state      <= state_next;
            good_count <= count_next;
            locked     <= (state_next == ST_LOCKED);
        end
    end

    // The line that lifts the FSM out of SEARCH counts toward lock if it measured good.
    always_comb begin
        state_next = state;
        count_next = good_count;
        case (state)
            ST_SEARCH: begin
                if (line_start && !timing_err) begin
                    state_next = ST_VERIFY;
                    count_next = line_good ? CW'(1) : '0;
                end
            end
            ST_VERIFY: begin
                if (timing_err) begin
                    state_next = ST_SEARCH;
                    count_next = '0;
                end else if (line_good) begin
                    if (good_count + 1'b1 == LOCK_CNT) begin
                        state_next = ST_LOCKED;
                        count_next = '0;
                    end else begin
                        count_next = good_count + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (timing_err) begin
                    state_next = ST_SEARCH;
                    count_next = '0;
                end
            end
            default: begin
                state_next = ST_SEARCH;
                count_next = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// tb_vga_sync_decoder: scoreboard bench with shrunken timing (12-clock lines, 7-line frames).
// Rev 1.0
module tb_vga_sync_decoder;

    logic        control_clock;
    logic        control_reset;
    logic        h_sync;
    logic        v_sync;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic        display_en;
    logic        line_start;
    logic        frame_start;
    logic        locked;
    logic        timing_err;

    int n_cmp = 0;
    int n_err = 0;
    int terr_seen = 0;

    typedef struct {
        int idx;
        int y;
        bit fs;
        bit terr;
        bit de;
        bit lk;
    } exp_t;

    exp_t sb[$];

    vga_sync_decoder #(
        .THRESHOLD_HSYNC (8),
        .THRESHOLD_VSYNC (5),
        .WHOLE_LINE      (12),
        .WHOLE_FRAME     (7),
        .COUNTER_SIZE    (11),
        .LOCK_LINES      (4)
    ) dut (
        .control_clock (control_clock),
        .control_reset (control_reset),
        .h_sync        (h_sync),
        .v_sync        (v_sync),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .display_en    (display_en),
        .line_start    (line_start),
        .frame_start   (frame_start),
        .locked        (locked),
        .timing_err    (timing_err)
    );

    initial control_clock = 1'b0;
    always #5 control_clock = ~control_clock;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pixel_x"}, int'(pixel_x), 0);
        chk({tag, "_pixel_y"}, int'(pixel_y), 0);
        chk({tag, "_display_en"}, int'(display_en), 0);
        chk({tag, "_line_start"}, int'(line_start), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_timing_err"}, int'(timing_err), 0);
    endtask

    // One line: h high for 'hi' clocks out of 'per'; v level set at the line's first clock.
    task automatic line(input int per, input int hi, input bit vv, input int idx,
                        input int y, input bit fs, input bit terr, input bit lk);
        exp_t e;
        e.idx  = idx;
        e.y    = y;
        e.fs   = fs;
        e.terr = terr;
        e.de   = vv && (hi > 0);
        e.lk   = lk;
        sb.push_back(e);
        for (int i = 0; i < per; i++) begin
            @(posedge control_clock);
            #1;
            h_sync = (i < hi);
            v_sync = vv;
        end
    endtask

    always @(negedge control_clock) begin
        if (timing_err === 1'b1) terr_seen++;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge control_clock);
            if (line_start === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_line_start", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("line%0d_pixel_x", e.idx), int'(pixel_x), 0);
                    chk($sformatf("line%0d_pixel_y", e.idx), int'(pixel_y), e.y);
                    chk($sformatf("line%0d_frame_start", e.idx), int'(frame_start), int'(e.fs));
                    chk($sformatf("line%0d_timing_err", e.idx), int'(timing_err), int'(e.terr));
                    chk($sformatf("line%0d_display_en", e.idx), int'(display_en), int'(e.de));
                    @(negedge control_clock);
                    chk($sformatf("line%0d_locked", e.idx), int'(locked), int'(e.lk));
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        control_reset = 1'b1;
        h_sync = 1'b0;
        v_sync = 1'b0;
        repeat (3) @(posedge control_clock);
        @(negedge control_clock);
        chk_all_zero("reset");
        @(posedge control_clock);
        #1 control_reset = 1'b0;
        repeat (3) @(posedge control_clock);

        // Three clean frames: lock after the 5th rise, no errors.
        for (int k = 0; k <= 20; k++)
            line(12, 8, (k % 7) < 5, k, k % 7, (k % 7) == 0, 1'b0, k >= 4);
        chk("terr_clean_frames", terr_seen, 0);

        // Short line while locked, then relock after 4 good lines.
        line(11, 8, 1'b1, 21, 0, 1'b1, 1'b0, 1'b1);
        line(12, 8, 1'b1, 22, 1, 1'b0, 1'b1, 1'b0);
        for (int k = 23; k <= 27; k++)
            line(12, 8, (k - 21) < 5, k, k - 21, 1'b0, 1'b0, k >= 26);
        line(12, 8, 1'b1, 28, 0, 1'b1, 1'b0, 1'b1);

        // High width 7 instead of 8: every following rise errors, never locks.
        line(12, 7, 1'b1, 29, 1, 1'b0, 1'b0, 1'b1);
        for (int k = 30; k <= 33; k++)
            line(12, 7, (k - 28) < 5, k, k - 28, 1'b0, 1'b1, 1'b0);
        line(12, 8, 1'b0, 34, 6, 1'b0, 1'b1, 1'b0);
        chk("terr_after_width", terr_seen, 6);

        // Relock, then hold h low until pixel_x saturates.
        for (int k = 35; k <= 38; k++)
            line(12, 8, 1'b1, k, k - 35, k == 35, 1'b0, k == 38);
        repeat (2100) @(posedge control_clock);
        @(negedge control_clock);
        chk("timeout_pixel_x", int'(pixel_x), 2047);
        chk("timeout_terr_count", terr_seen, 7);
        chk("timeout_locked", int'(locked), 0);

        // First rise after timeout is exempt; frame of 7 lines still checks clean.
        line(12, 8, 1'b1, 39, 4, 1'b0, 1'b0, 1'b0);
        line(12, 8, 1'b0, 40, 5, 1'b0, 1'b0, 1'b0);
        line(12, 8, 1'b0, 41, 6, 1'b0, 1'b0, 1'b0);
        line(12, 8, 1'b1, 42, 0, 1'b1, 1'b0, 1'b0);
        line(12, 8, 1'b1, 43, 1, 1'b0, 1'b0, 1'b1);

        // v held high so pixel_y climbs to 300.
        for (int k = 44; k <= 341; k++)
            line(12, 8, 1'b1, k, k - 42, 1'b0, 1'b0, 1'b1);

        // Long line: reset lands at pixel_x=500, pixel_y=300.
        begin
            exp_t e;
            e.idx = 342; e.y = 300; e.fs = 1'b0; e.terr = 1'b0; e.de = 1'b1; e.lk = 1'b1;
            sb.push_back(e);
        end
        @(posedge control_clock);
        #1;
        h_sync = 1'b1;
        v_sync = 1'b1;
        repeat (8) @(posedge control_clock);
        #1 h_sync = 1'b0;
        repeat (493) @(posedge control_clock);
        @(negedge control_clock);
        chk("prereset_pixel_x", int'(pixel_x), 500);
        chk("prereset_pixel_y", int'(pixel_y), 300);
        control_reset = 1'b1;
        @(negedge control_clock);
        chk_all_zero("midline_reset");
        @(posedge control_clock);
        #1 control_reset = 1'b0;

        line(12, 8, 1'b1, 343, 0, 1'b1, 1'b0, 1'b0);
        line(12, 8, 1'b1, 344, 1, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge control_clock);
        @(negedge control_clock);
        chk("final_terr_count", terr_seen, 7);
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
